// File: rtl/dme_seq_pkg.sv
// Shared definitions for the DME reset sequencer.
// Holds the state encoding, the default status-bit indices and the helper
// that sizes the sequencer's cycle counter.
package dme_seq_pkg;

  localparam logic [2:0] S_ABSENT   = 3'd0;
  localparam logic [2:0] S_WAIT_PWR = 3'd1;
  localparam logic [2:0] S_DEBOUNCE = 3'd2;
  localparam logic [2:0] S_HOLD     = 3'd3;
  localparam logic [2:0] S_WAIT_RDY = 3'd4;
  localparam logic [2:0] S_RUN      = 3'd5;
  localparam logic [2:0] S_FAULT    = 3'd6;

  typedef enum logic [2:0] {
    ST_ABSENT   = S_ABSENT,
    ST_WAIT_PWR = S_WAIT_PWR,
    ST_DEBOUNCE = S_DEBOUNCE,
    ST_HOLD     = S_HOLD,
    ST_WAIT_RDY = S_WAIT_RDY,
    ST_RUN      = S_RUN,
    ST_FAULT    = S_FAULT
  } seq_state_e;

  localparam int RDY_BIT_DEF = 0;
  localparam int FLT_BIT_DEF = 5;

  // Counter must be able to hold the largest of the three cycle limits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dme_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk_sys  in  sampling clock
//   rst_sys  in  synchronous active-high reset, loads RST_VAL into both flops
//   d        in  asynchronous input
//   q        out synchronised output, two cycles behind d
module dme_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_sys,
  input  logic rst_sys,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dme_reset_sequencer.sv
// DME reset sequencer: qualifies DME power good, holds the DME in reset,
// releases it, then waits for the DME to report ready. Reports ready/fault
// status and the DME ID captured at release.
// Ports:
//   CLK_SYS       in   system clock
//   RST_SYS       in   synchronous active-high reset
//   RST_PLTRST_N  in   platform reset (async, active-low)
//   DME_PWRGD     in   DME power good (async)
//   DME_Absent    in   1 = DME absent (async)
//   DMEID         in   DME ID straps, static while powered
//   DMEStatus     in   DME status (async, quasi-static)
//   RST_DME_N     out  DME reset, active-low
//   DMEReady      out  DME in RUN
//   DMEFault      out  DME in FAULT
//   DMEIDLatched  out  DMEID captured when reset is released
//   SeqState      out  current state encoding
//
// state    | meaning
// ABSENT   | no DME fitted, reset asserted
// WAIT_PWR | DME fitted, waiting for power good and platform reset release
// DEBOUNCE | power good must stay stable for PWRGD_DEB_CYC cycles
// HOLD     | reset held for RST_HOLD_CYC cycles
// WAIT_RDY | reset released, waiting up to RDY_TMO_CYC for ready
// RUN      | DME operational
// FAULT    | ready timeout or runtime fault; sticky until platform reset
module dme_reset_sequencer
  import dme_seq_pkg::*;
#(
  parameter int PWRGD_DEB_CYC = 16,
  parameter int RST_HOLD_CYC  = 100,
  parameter int RDY_TMO_CYC   = 1000,
  parameter int RDY_BIT       = RDY_BIT_DEF,
  parameter int FLT_BIT       = FLT_BIT_DEF
) (
  input  logic       CLK_SYS,
  input  logic       RST_SYS,
  input  logic       RST_PLTRST_N,
  input  logic       DME_PWRGD,
  input  logic       DME_Absent,
  input  logic [3:0] DMEID,
  input  logic [5:0] DMEStatus,
  output logic       RST_DME_N,
  output logic       DMEReady,
  output logic       DMEFault,
  output logic [3:0] DMEIDLatched,
  output logic [2:0] SeqState
);

  localparam int CNT_W = cnt_width(PWRGD_DEB_CYC, RST_HOLD_CYC, RDY_TMO_CYC);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(PWRGD_DEB_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(RDY_TMO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic pltrst_s, pwrgd_s, absent_s, rdy_s, flt_s;

  dme_sync2 #(.RST_VAL(1'b0)) u_sync_pltrst (
    .clk_sys(CLK_SYS), .rst_sys(RST_SYS), .d(RST_PLTRST_N), .q(pltrst_s));
  dme_sync2 #(.RST_VAL(1'b0)) u_sync_pwrgd (
    .clk_sys(CLK_SYS), .rst_sys(RST_SYS), .d(DME_PWRGD), .q(pwrgd_s));
  dme_sync2 #(.RST_VAL(1'b1)) u_sync_absent (
    .clk_sys(CLK_SYS), .rst_sys(RST_SYS), .d(DME_Absent), .q(absent_s));
  dme_sync2 #(.RST_VAL(1'b0)) u_sync_rdy (
    .clk_sys(CLK_SYS), .rst_sys(RST_SYS), .d(DMEStatus[RDY_BIT]), .q(rdy_s));
  dme_sync2 #(.RST_VAL(1'b0)) u_sync_flt (
    .clk_sys(CLK_SYS), .rst_sys(RST_SYS), .d(DMEStatus[FLT_BIT]), .q(flt_s));

  // Status bits other than ready/fault carry no meaning for sequencing.
  logic unused_status;
  assign unused_status = ^DMEStatus;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       id_q, id_d;
  logic             rst_dme_n_q, rst_dme_n_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             powered;

  always_comb begin
    powered = (state_q == ST_DEBOUNCE) || (state_q == ST_HOLD) ||
              (state_q == ST_WAIT_RDY) || (state_q == ST_RUN);
    state_d = state_q;
    // Removal beats loss of power/platform reset, which beat the per-state rules.
    if (absent_s) begin
      state_d = ST_ABSENT;
    end else if (powered && (!pwrgd_s || !pltrst_s)) begin
      state_d = ST_WAIT_PWR;
    end else begin
      case (state_q)
        ST_ABSENT:   state_d = ST_WAIT_PWR;
        ST_WAIT_PWR: if (pwrgd_s && pltrst_s) state_d = ST_DEBOUNCE;
        ST_DEBOUNCE: if (cnt_q == DEB_LAST) state_d = ST_HOLD;
        ST_HOLD:     if (cnt_q == HOLD_LAST) state_d = ST_WAIT_RDY;
        // Ready wins over a coincident timeout; fault is not watched yet.
        ST_WAIT_RDY: begin
          if (rdy_s)                  state_d = ST_RUN;
          else if (cnt_q == TMO_LAST) state_d = ST_FAULT;
        end
        ST_RUN:      if (flt_s) state_d = ST_FAULT;
        ST_FAULT:    if (!pltrst_s) state_d = ST_WAIT_PWR;
        default:     state_d = ST_ABSENT;
      endcase
    end

    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + CNT_W'(1);

    id_d = (state_q == ST_HOLD && state_d == ST_WAIT_RDY) ? DMEID : id_q;

    // Outputs follow the next state so they switch on the same edge.
    rst_dme_n_d = (state_d == ST_WAIT_RDY) || (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge CLK_SYS) begin
    if (RST_SYS) begin
      state_q     <= ST_ABSENT;
      cnt_q       <= '0;
      id_q        <= '0;
      rst_dme_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      rst_dme_n_q <= rst_dme_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign RST_DME_N    = rst_dme_n_q;
  assign DMEReady     = ready_q;
  assign DMEFault     = fault_q;
  assign DMEIDLatched = id_q;
  assign SeqState     = state_q;

endmodule

// File: tb/tb_dme_reset_sequencer.sv
// Scoreboard bench for dme_reset_sequencer. Stimulus tasks predict each state
// transition (state, cycle, latched ID) from the sequencing timing rules and
// queue it; a negedge monitor pops an entry on every observed state change
// and checks the outputs every cycle against the expected current state.
module tb_dme_reset_sequencer;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int TMO  = 20;
  localparam int SYNC = 2;

  localparam int E_ABSENT = 0, E_WAIT_PWR = 1, E_DEBOUNCE = 2, E_HOLD = 3,
                 E_WAIT_RDY = 4, E_RUN = 5, E_FAULT = 6;

  logic       CLK_SYS = 1'b0;
  logic       RST_SYS;
  logic       RST_PLTRST_N;
  logic       DME_PWRGD;
  logic       DME_Absent;
  logic [3:0] DMEID;
  logic [5:0] DMEStatus;
  logic       RST_DME_N;
  logic       DMEReady;
  logic       DMEFault;
  logic [3:0] DMEIDLatched;
  logic [2:0] SeqState;

  dme_reset_sequencer #(
    .PWRGD_DEB_CYC(DEB),
    .RST_HOLD_CYC(HOLD),
    .RDY_TMO_CYC(TMO),
    .RDY_BIT(0),
    .FLT_BIT(5)
  ) dut (
    .CLK_SYS(CLK_SYS),
    .RST_SYS(RST_SYS),
    .RST_PLTRST_N(RST_PLTRST_N),
    .DME_PWRGD(DME_PWRGD),
    .DME_Absent(DME_Absent),
    .DMEID(DMEID),
    .DMEStatus(DMEStatus),
    .RST_DME_N(RST_DME_N),
    .DMEReady(DMEReady),
    .DMEFault(DMEFault),
    .DMEIDLatched(DMEIDLatched),
    .SeqState(SeqState)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  int cyc = 0;
  always @(posedge CLK_SYS) cyc <= cyc + 1;

  typedef struct {
    int st;
    int at;
    int id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_en   = 1'b0;
  int   prev_st  = E_ABSENT;
  int   cur_st   = E_ABSENT;
  int   cur_id   = 0;
  int   exp_id   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  task automatic push(input int st, input int at);
    exp_t e;
    e.st = st;
    e.at = at;
    e.id = exp_id;
    exp_q.push_back(e);
  endtask

  always @(negedge CLK_SYS) begin
    if (mon_en) begin
      if (int'(SeqState) != prev_st) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_transition at cycle %0d: got state %0d, required state %0d",
                   cyc, SeqState, prev_st);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("state", int'(SeqState), e.st);
          chk("transition_cycle", cyc, e.at);
          cur_st = e.st;
          cur_id = e.id;
        end
        prev_st = int'(SeqState);
      end
      chk("rst_dme_n", int'(RST_DME_N), (cur_st == E_WAIT_RDY || cur_st == E_RUN) ? 1 : 0);
      chk("dme_ready", int'(DMEReady), (cur_st == E_RUN) ? 1 : 0);
      chk("dme_fault", int'(DMEFault), (cur_st == E_FAULT) ? 1 : 0);
      chk("dme_id_latched", int'(DMEIDLatched), cur_id);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d: got no finish, required finish", cyc);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK_SYS);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic drained();
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // From ABSENT: plug the DME in with power off.
  task automatic bring_present();
    int t;
    t = cyc;
    DME_PWRGD    = 1'b0;
    RST_PLTRST_N = 1'b1;
    DMEStatus    = '0;
    DME_Absent   = 1'b0;
    push(E_WAIT_PWR, t + SYNC + 1);
    step(SYNC + 1 + $urandom_range(0, 2));
  endtask

  // From WAIT_PWR: power up; predicts debounce and hold entry.
  task automatic power_up(output int t0);
    t0 = cyc;
    DMEID     = 4'($urandom_range(1, 15));
    DME_PWRGD = 1'b1;
    push(E_DEBOUNCE, t0 + SYNC + 1);
    push(E_HOLD, t0 + SYNC + 1 + DEB);
  endtask

  task automatic release_at(input int t0, output int t_rel);
    t_rel  = t0 + SYNC + 1 + DEB + HOLD;
    exp_id = int'(DMEID);
    push(E_WAIT_RDY, t_rel);
  endtask

  task automatic remove(input bit drop_pwr);
    int ta;
    ta = cyc;
    DME_Absent = 1'b1;
    if (drop_pwr) DME_PWRGD = 1'b0;
    push(E_ABSENT, ta + SYNC + 1);
    step(SYNC + 2);
    DME_PWRGD = 1'b0;
    DMEStatus = '0;
    drained();
  endtask

  task automatic scen_nominal(input int d, input bit do_fault, input bit drop);
    int t0, t_rel, tf;
    bring_present();
    power_up(t0);
    release_at(t0, t_rel);
    wait_until(t_rel + d);
    DMEStatus[0] = 1'b1;
    push(E_RUN, t_rel + d + SYNC + 1);
    wait_until(t_rel + d + SYNC + 2 + $urandom_range(0, 4));
    if (do_fault) begin
      tf = cyc;
      DMEStatus[5] = 1'b1;
      push(E_FAULT, tf + SYNC + 1);
      wait_until(tf + SYNC + 2);
    end
    remove(drop);
  endtask

  task automatic scen_glitch();
    int t0, k;
    bring_present();
    t0 = cyc;
    k  = $urandom_range(1, 3);
    DME_PWRGD = 1'b1;
    push(E_DEBOUNCE, t0 + SYNC + 1);
    push(E_WAIT_PWR, t0 + k + SYNC + 1);
    step(k);
    DME_PWRGD = 1'b0;
    wait_until(t0 + k + SYNC + 3);
    drained();
    remove($urandom_range(0, 1) == 1);
  endtask

  task automatic scen_timeout();
    int t0, t_rel, tp;
    bring_present();
    power_up(t0);
    release_at(t0, t_rel);
    push(E_FAULT, t_rel + TMO);
    wait_until(t_rel + TMO + 2 + $urandom_range(0, 3));
    tp = cyc;
    RST_PLTRST_N = 1'b0;
    DME_PWRGD    = 1'b0;
    push(E_WAIT_PWR, tp + SYNC + 1);
    step($urandom_range(1, 3));
    RST_PLTRST_N = 1'b1;
    wait_until(tp + SYNC + 4);
    drained();
    remove(1'b0);
  endtask

  task automatic scen_reset_mid(input bit in_run);
    int t0, t_rel, d, c;
    bring_present();
    power_up(t0);
    if (in_run) begin
      release_at(t0, t_rel);
      d = $urandom_range(0, 10);
      wait_until(t_rel + d);
      DMEStatus[0] = 1'b1;
      push(E_RUN, t_rel + d + SYNC + 1);
      wait_until(t_rel + d + SYNC + 1 + $urandom_range(1, 5));
    end else begin
      wait_until(t0 + SYNC + 1 + DEB + $urandom_range(0, HOLD - 1));
    end
    c = cyc;
    RST_SYS    = 1'b1;
    DME_Absent = 1'b1;
    DME_PWRGD  = 1'b0;
    DMEStatus  = '0;
    exp_id     = 0;
    push(E_ABSENT, c + 1);
    step(1);
    RST_SYS = 1'b0;
    step(SYNC + 2);
    drained();
  endtask

  initial begin
    RST_SYS      = 1'b1;
    RST_PLTRST_N = 1'b1;
    DME_PWRGD    = 1'b0;
    DME_Absent   = 1'b1;
    DMEID        = 4'h0;
    DMEStatus    = '0;
    step(3);
    @(negedge CLK_SYS);
    chk("reset_state", int'(SeqState), E_ABSENT);
    chk("reset_rst_dme_n", int'(RST_DME_N), 0);
    chk("reset_ready", int'(DMEReady), 0);
    chk("reset_fault", int'(DMEFault), 0);
    chk("reset_id", int'(DMEIDLatched), 0);
    mon_en = 1'b1;
    step(1);
    RST_SYS = 1'b0;
    step(3);

    scen_nominal(5, 1'b1, 1'b1);
    scen_nominal(TMO - SYNC - 1, 1'b0, 1'b1);
    scen_glitch();
    scen_timeout();
    scen_reset_mid(1'b0);
    scen_reset_mid(1'b1);

    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 4))
        0: scen_nominal($urandom_range(0, TMO - SYNC - 1), $urandom_range(0, 1) == 1,
                        $urandom_range(0, 1) == 1);
        1: scen_glitch();
        2: scen_timeout();
        3: scen_reset_mid($urandom_range(0, 1) == 1);
        default: scen_nominal(0, 1'b0, 1'b1);
      endcase
    end

    step(2);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
